// File: rtl/eeprom_pkg.sv
`default_nettype none
//==============================================================================
// Package  : eeprom_pkg
// Brief    : Shared constants for the AT24C02 command path (state codes,
//            device address, 50 MHz timing defaults).
// Revision : 1.0 - initial release
//==============================================================================
package eeprom_pkg;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_WR_ISSUE = 3'd1;
    localparam logic [2:0] c_ST_WR_WAIT  = 3'd2;
    localparam logic [2:0] c_ST_TWR_HOLD = 3'd3;
    localparam logic [2:0] c_ST_RD_ISSUE = 3'd4;
    localparam logic [2:0] c_ST_RD_WAIT  = 3'd5;

    localparam logic [6:0] c_AT24C02_ADDR = 7'b1010_000;

    // 5 ms write cycle and 10 ms bus guard at 50 MHz
    localparam int unsigned c_TWR_CYC_50M     = 250000;
    localparam int unsigned c_TIMEOUT_CYC_50M = 500000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/eeprom_cmd_sched.sv
`default_nettype none
//==============================================================================
// Module   : eeprom_cmd_sched
// Brief    : Queues key-driven EEPROM write/read requests, issues one-cycle
//            triggers to the I2C controller, guards tWR and bus time-outs.
// Revision : 1.0 - initial release
//==============================================================================
module eeprom_cmd_sched
    import eeprom_pkg::*;
#(
    parameter int unsigned TWR_CYC     = c_TWR_CYC_50M,
    parameter int unsigned TIMEOUT_CYC = c_TIMEOUT_CYC_50M
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] wr_data,
    input  logic       write_done,
    input  logic       read_done,
    input  logic [7:0] read_byte,
    output logic       write_trigger,
    output logic       read_trigger,
    output logic [7:0] write_byte,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       timeout_err
);

    localparam int unsigned     c_CNT_MAX  = max_u(TWR_CYC, TIMEOUT_CYC);
    localparam int unsigned     c_CW       = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CW-1:0] c_TWR_LAST = c_CW'(TWR_CYC - 1);
    localparam logic [c_CW-1:0] c_TO_LAST  = c_CW'(TIMEOUT_CYC - 1);
    localparam logic [c_CW-1:0] c_CNT_SAT  = c_CW'(c_CNT_MAX);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [c_CW-1:0] r_cnt;
    logic [c_CW-1:0] w_cnt_nxt;
    logic            w_to_term;

    logic            r_wr_pend;
    logic            r_rd_pend;
    logic [7:0]      r_wr_buf;

    logic            w_wr_issue;
    logic            w_rd_issue;
    logic            w_rd_ok;
    logic            w_timeout;
    logic            w_busy_nxt;

    logic            r_write_trigger;
    logic            r_read_trigger;
    logic [7:0]      r_write_byte;
    logic            r_busy;
    logic [7:0]      r_rd_data;
    logic            r_rd_valid;
    logic            r_timeout_err;

    assign w_to_term = (r_cnt == c_TO_LAST);

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A done pulse on the terminal-count cycle wins over the time-out.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_wr_pend) begin
                    w_state_nxt = c_ST_WR_ISSUE;
                end else if (r_rd_pend) begin
                    w_state_nxt = c_ST_RD_ISSUE;
                end
            end
            c_ST_WR_ISSUE: w_state_nxt = c_ST_WR_WAIT;
            c_ST_WR_WAIT: begin
                if (write_done) begin
                    w_state_nxt = c_ST_TWR_HOLD;
                end else if (w_to_term) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_TWR_HOLD: begin
                if (r_cnt == c_TWR_LAST) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            c_ST_RD_ISSUE: w_state_nxt = c_ST_RD_WAIT;
            c_ST_RD_WAIT: begin
                if (read_done || w_to_term) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Counter restarts on every state change and saturates rather than wrapping.
    always_comb begin
        if ((r_state == c_ST_IDLE) || (w_state_nxt != r_state)) begin
            w_cnt_nxt = '0;
        end else if (r_cnt == c_CNT_SAT) begin
            w_cnt_nxt = r_cnt;
        end else begin
            w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
    end

    always_comb begin
        w_wr_issue = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_WR_ISSUE);
        w_rd_issue = (r_state == c_ST_IDLE) && (w_state_nxt == c_ST_RD_ISSUE);
        w_rd_ok    = (r_state == c_ST_RD_WAIT) && read_done;
        w_timeout  = w_to_term &&
                     (((r_state == c_ST_WR_WAIT) && !write_done) ||
                      ((r_state == c_ST_RD_WAIT) && !read_done));
        w_busy_nxt = (w_state_nxt != c_ST_IDLE);
    end

    // A request arriving on the consume cycle re-arms its flag.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_wr_buf  <= 8'h00;
        end else begin
            if (wr_req) begin
                r_wr_pend <= 1'b1;
                r_wr_buf  <= wr_data;
            end else if (w_wr_issue) begin
                r_wr_pend <= 1'b0;
            end
            if (rd_req) begin
                r_rd_pend <= 1'b1;
            end else if (w_rd_issue) begin
                r_rd_pend <= 1'b0;
            end
        end
    end

    // Outputs are loaded from next-state decode so they line up with the state they announce.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_write_trigger <= 1'b0;
            r_read_trigger  <= 1'b0;
            r_write_byte    <= 8'h00;
            r_busy          <= 1'b0;
            r_rd_data       <= 8'h00;
            r_rd_valid      <= 1'b0;
            r_timeout_err   <= 1'b0;
        end else begin
            r_write_trigger <= w_wr_issue;
            r_read_trigger  <= w_rd_issue;
            r_busy          <= w_busy_nxt;
            r_rd_valid      <= w_rd_ok;
            r_timeout_err   <= w_timeout;
            if (w_wr_issue) begin
                r_write_byte <= r_wr_buf;
            end
            if (w_rd_ok) begin
                r_rd_data <= read_byte;
            end
        end
    end

    assign write_trigger = r_write_trigger;
    assign read_trigger  = r_read_trigger;
    assign write_byte    = r_write_byte;
    assign busy          = r_busy;
    assign rd_data       = r_rd_data;
    assign rd_valid      = r_rd_valid;
    assign timeout_err   = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_eeprom_cmd_sched.sv
`default_nettype none
//==============================================================================
// Module   : tb_eeprom_cmd_sched
// Brief    : Scoreboard bench for eeprom_cmd_sched; a transaction-level model
//            predicts every trigger, result and busy edge with its cycle.
// Revision : 1.0 - initial release
//==============================================================================
module tb_eeprom_cmd_sched;

    localparam int TWR = 100;
    localparam int TO  = 1000;

    localparam int EV_WT   = 0;
    localparam int EV_RT   = 1;
    localparam int EV_RV   = 2;
    localparam int EV_TO   = 3;
    localparam int EV_RISE = 4;
    localparam int EV_FALL = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       write_done = 1'b0;
    logic       read_done = 1'b0;
    logic [7:0] read_byte = 8'h00;
    logic       write_trigger;
    logic       read_trigger;
    logic [7:0] write_byte;
    logic       busy;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       timeout_err;

    eeprom_cmd_sched #(
        .TWR_CYC    (TWR),
        .TIMEOUT_CYC(TO)
    ) dut (
        .sclk         (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_data      (wr_data),
        .write_done   (write_done),
        .read_done    (read_done),
        .read_byte    (read_byte),
        .write_trigger(write_trigger),
        .read_trigger (read_trigger),
        .write_byte   (write_byte),
        .busy         (busy),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] model_rd = 8'h00;
    logic [7:0] mon_wb = 8'h00;
    logic       prev_busy = 1'b0;

    logic [7:0] plan_wr[int];
    bit         plan_rd[int];
    bit         plan_wd[int];
    logic [7:0] plan_rdd[int];

    function automatic string kname(input int k);
        case (k)
            EV_WT:   return "write_trigger";
            EV_RT:   return "read_trigger";
            EV_RV:   return "rd_valid";
            EV_TO:   return "timeout_err";
            EV_RISE: return "busy_rise";
            default: return "busy_fall";
        endcase
    endfunction

    function automatic void push_ev(input int c, input int k, input logic [7:0] d);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.data = d;
        exp_q.push_back(e);
    endfunction

    // Write issued at cycle t; dly==0 means the controller never answers.
    // Returns the first cycle the scheduler is idle again.
    function automatic int model_write(input int t, input logic [7:0] d, input int dly, input bit spur);
        push_ev(t, EV_WT, d);
        push_ev(t, EV_RISE, 8'h00);
        if (dly == 0) begin
            push_ev(t + TO + 1, EV_TO, model_rd);
            push_ev(t + TO + 1, EV_FALL, 8'h00);
            return t + TO + 1;
        end
        plan_wd[t + dly] = 1'b1;
        if (spur) begin
            plan_rdd[t + 1 + int'($urandom_range(0, dly - 1))] = 8'($urandom);
            plan_wd[t + dly + 1 + int'($urandom_range(0, TWR - 1))] = 1'b1;
        end
        push_ev(t + dly + TWR + 1, EV_FALL, 8'h00);
        return t + dly + TWR + 1;
    endfunction

    function automatic int model_read(input int r, input logic [7:0] b, input int dly, input bit spur);
        push_ev(r, EV_RT, model_rd);
        push_ev(r, EV_RISE, 8'h00);
        if (dly == 0) begin
            if (spur) plan_wd[r + 1 + int'($urandom_range(0, TO - 1))] = 1'b1;
            push_ev(r + TO + 1, EV_TO, model_rd);
            push_ev(r + TO + 1, EV_FALL, 8'h00);
            return r + TO + 1;
        end
        plan_rdd[r + dly] = b;
        if (spur) plan_wd[r + 1 + int'($urandom_range(0, dly - 1))] = 1'b1;
        model_rd = b;
        push_ev(r + dly + 1, EV_RV, b);
        push_ev(r + dly + 1, EV_FALL, 8'h00);
        return r + dly + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic run_until(input int end_cyc);
        while (cyc < end_cyc) begin
            wr_req     = (plan_wr.exists(cyc) != 0);
            wr_data    = wr_req ? plan_wr[cyc] : 8'($urandom);
            rd_req     = (plan_rd.exists(cyc) != 0);
            write_done = (plan_wd.exists(cyc) != 0);
            read_done  = (plan_rdd.exists(cyc) != 0);
            read_byte  = read_done ? plan_rdd[cyc] : 8'($urandom);
            @(posedge clk);
            #1;
        end
        wr_req     = 1'b0;
        rd_req     = 1'b0;
        write_done = 1'b0;
        read_done  = 1'b0;
        plan_wr.delete();
        plan_rd.delete();
        plan_wd.delete();
        plan_rdd.delete();
    endtask

    task automatic episode(input bit do_wr, input logic [7:0] wd, input int wdly,
                           input bit do_rd, input logic [7:0] rb, input int rdly, input bit spur);
        int n;
        int t_end;
        n     = cyc;
        t_end = n;
        if (do_wr) plan_wr[n] = wd;
        if (do_rd) plan_rd[n] = 1'b1;
        if (do_wr) begin
            t_end = model_write(n + 2, wd, wdly, spur);
            if (do_rd) t_end = model_read(t_end + 1, rb, rdly, spur);
        end else if (do_rd) begin
            t_end = model_read(n + 2, rb, rdly, spur);
        end
        run_until(t_end);
    endtask

    function automatic int pick_dly();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return 0;
        if (r == 1) return TO;
        if (r == 2) return 1;
        return int'($urandom_range(2, 60));
    endfunction

    task automatic expect_ev(input int kind, input logic [7:0] act);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_%s cyc=%0d actual=asserted required=quiet", kname(kind), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != cyc) begin
                failures++;
                $display("FAIL event_order actual=%s@%0d required=%s@%0d",
                         kname(kind), cyc, kname(e.kind), e.cyc);
            end
            if (kind <= EV_TO) begin
                checks++;
                if (act !== e.data) begin
                    failures++;
                    $display("FAIL data_%s cyc=%0d actual=0x%02h required=0x%02h",
                             kname(kind), cyc, act, e.data);
                end
            end
            if (kind == EV_WT) mon_wb = e.data;
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_busy = 1'b0;
            mon_wb    = 8'h00;
        end else begin
            if (write_trigger) expect_ev(EV_WT, write_byte);
            if (read_trigger)  expect_ev(EV_RT, rd_data);
            if (rd_valid)      expect_ev(EV_RV, rd_data);
            if (timeout_err)   expect_ev(EV_TO, rd_data);
            if (busy && !prev_busy) expect_ev(EV_RISE, 8'h00);
            if (!busy && prev_busy) expect_ev(EV_FALL, 8'h00);
            prev_busy = busy;
            checks++;
            if (write_byte !== mon_wb) begin
                failures++;
                $display("FAIL write_byte_hold cyc=%0d actual=0x%02h required=0x%02h", cyc, write_byte, mon_wb);
            end
        end
    end

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int t1;
        int t2;
        bit dw;
        bit dr;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_write_trigger", {31'd0, write_trigger}, 32'd0);
        chk("reset_read_trigger",  {31'd0, read_trigger},  32'd0);
        chk("reset_write_byte",    {24'd0, write_byte},    32'd0);
        chk("reset_busy",          {31'd0, busy},          32'd0);
        chk("reset_rd_data",       {24'd0, rd_data},       32'd0);
        chk("reset_rd_valid",      {31'd0, rd_valid},      32'd0);
        chk("reset_timeout_err",   {31'd0, timeout_err},   32'd0);
        rst = 1'b0;

        // single write, single read, simultaneous request
        episode(1'b1, 8'h69, 20, 1'b0, 8'h00, 0, 1'b0);
        episode(1'b0, 8'h00, 0, 1'b1, 8'hA5, 30, 1'b0);
        episode(1'b1, 8'h3C, 7, 1'b1, 8'h5E, 12, 1'b0);

        // unanswered write and read, then a read that completes
        episode(1'b1, 8'h77, 0, 1'b0, 8'h00, 0, 1'b0);
        episode(1'b0, 8'h00, 0, 1'b1, 8'h00, 0, 1'b0);
        episode(1'b0, 8'h00, 0, 1'b1, 8'h96, 5, 1'b0);

        // done on the terminal-count cycle
        episode(1'b1, 8'hE1, TO, 1'b1, 8'h1E, TO, 1'b0);

        // two overwriting requests during tWR hold
        n  = cyc;
        plan_wr[n] = 8'h5A;
        t1 = model_write(n + 2, 8'h5A, 10, 1'b0);
        plan_wr[n + 2 + 10 + 20] = 8'h11;
        plan_wr[n + 2 + 10 + 50] = 8'h22;
        t2 = model_write(t1 + 1, 8'h22, 15, 1'b0);
        run_until(t2);

        for (int i = 0; i < 30; i++) begin
            dw = 1'($urandom_range(0, 1));
            dr = dw ? 1'($urandom_range(0, 1)) : 1'b1;
            episode(dw, 8'($urandom), pick_dly(), dr, 8'($urandom), pick_dly(), 1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a read wait
        n = cyc;
        plan_rd[n] = 1'b1;
        push_ev(n + 2, EV_RT, model_rd);
        push_ev(n + 2, EV_RISE, 8'h00);
        run_until(n + 12);
        rst = 1'b1;
        #1;
        chk("async_rst_busy",          {31'd0, busy},          32'd0);
        chk("async_rst_rd_data",       {24'd0, rd_data},       32'd0);
        chk("async_rst_write_byte",    {24'd0, write_byte},    32'd0);
        chk("async_rst_read_trigger",  {31'd0, read_trigger},  32'd0);
        chk("async_rst_write_trigger", {31'd0, write_trigger}, 32'd0);
        chk("async_rst_rd_valid",      {31'd0, rd_valid},      32'd0);
        chk("async_rst_timeout_err",   {31'd0, timeout_err},   32'd0);
        model_rd = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        read_done = 1'b1;
        read_byte = 8'hC3;
        @(posedge clk);
        #1;
        read_done = 1'b0;
        episode(1'b0, 8'h00, 0, 1'b1, 8'h3C, 25, 1'b0);

        run_until(cyc + 5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_events actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
